pipeline_tracker: RTL

Synthesizable bookkeeping block that tags every fetched instruction with a sequence ID and carries valid/ID/halt tags through the five pipeline stages (IF, ID, EX, MEM, WB). It mirrors the CPU's stall/flush behaviour exactly: on a stall, IF and ID hold and EX receives a bubble. It sits beside the CPU pipeline, driven by the hazard unit's stall and the branch unit's flush. It feeds the per-stage valid/ID tags, the retire pulse and the halt indication to the downstream verification and debug logic.

---
 rtl/pipeline_tracker.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pipeline_tracker.sv
// Sequence-ID and valid/halt tag tracker that runs beside a five-stage pipeline.
// It follows the CPU's stall and flush behaviour and reports retirement, cycle count and halt completion.
module pipeline_tracker #(
  parameter int ID_W  = 7,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             fetch_hlt,
  output logic             if_valid,
  output logic             id_valid,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [ID_W-1:0]  if_tag,
  output logic [ID_W-1:0]  id_tag,
  output logic [ID_W-1:0]  ex_tag,
  output logic [ID_W-1:0]  mem_tag,
  output logic [ID_W-1:0]  wb_tag,
  output logic             retire,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done
);

  localparam logic [ID_W-1:0]  ID_ONE  = ID_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             if_valid_r, id_valid_r, ex_valid_r, mem_valid_r, wb_valid_r;
  logic [ID_W-1:0]  if_tag_r, id_tag_r, ex_tag_r, mem_tag_r, wb_tag_r;
  logic             id_hlt_r, ex_hlt_r, mem_hlt_r, wb_hlt_r;
  logic [ID_W-1:0]  next_id_r;
  logic             halted_fetch_r;
  logic             done_r;
  logic [CNT_W-1:0] retire_count_r, cycle_count_r;

  logic advance_s;
  logic halt_now_s;
  logic fetch_valid_s;

  // Decide whether this edge captures a HLT and whether the refilled IF entry is live.
  always_comb begin
    advance_s     = 1'b0;
    halt_now_s    = 1'b0;
    fetch_valid_s = 1'b0;
    if (!stall && !flush) begin
      advance_s = 1'b1;
    end else begin
      advance_s = 1'b0;
    end
    halt_now_s    = advance_s & if_valid_r & fetch_hlt;
    // The entry loaded on the HLT edge is already dead, so nothing after the HLT retires.
    fetch_valid_s = ~(halted_fetch_r | halt_now_s);
  end

  // Stage tags, fetch bookkeeping and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_r     <= 1'b1;
      id_valid_r     <= 1'b0;
      ex_valid_r     <= 1'b0;
      mem_valid_r    <= 1'b0;
      wb_valid_r     <= 1'b0;
      if_tag_r       <= '0;
      id_tag_r       <= '0;
      ex_tag_r       <= '0;
      mem_tag_r      <= '0;
      wb_tag_r       <= '0;
      id_hlt_r       <= 1'b0;
      ex_hlt_r       <= 1'b0;
      mem_hlt_r      <= 1'b0;
      wb_hlt_r       <= 1'b0;
      next_id_r      <= ID_ONE;
      halted_fetch_r <= 1'b0;
      done_r         <= 1'b0;
      retire_count_r <= '0;
      cycle_count_r  <= '0;
    end else begin
      wb_valid_r  <= mem_valid_r;
      wb_tag_r    <= mem_tag_r;
      wb_hlt_r    <= mem_hlt_r;
      mem_valid_r <= ex_valid_r;
      mem_tag_r   <= ex_tag_r;
      mem_hlt_r   <= ex_hlt_r;

      if (stall) begin
        ex_valid_r <= 1'b0;
        ex_tag_r   <= id_tag_r;
        ex_hlt_r   <= 1'b0;
      end else begin
        ex_valid_r <= id_valid_r;
        ex_tag_r   <= id_tag_r;
        ex_hlt_r   <= id_hlt_r;
        if (flush) begin
          id_valid_r <= 1'b0;
          id_tag_r   <= if_tag_r;
          id_hlt_r   <= 1'b0;
        end else begin
          id_valid_r <= if_valid_r;
          id_tag_r   <= if_tag_r;
          id_hlt_r   <= halt_now_s;
          if (halt_now_s) begin
            halted_fetch_r <= 1'b1;
          end
        end
        if_valid_r <= fetch_valid_s;
        if_tag_r   <= next_id_r;
        if (fetch_valid_s) begin
          next_id_r <= next_id_r + ID_ONE;
        end
      end

      if (wb_valid_r && wb_hlt_r) begin
        done_r <= 1'b1;
      end
      if (wb_valid_r) begin
        retire_count_r <= retire_count_r + CNT_ONE;
      end
      if (!done_r) begin
        cycle_count_r <= cycle_count_r + CNT_ONE;
      end
    end
  end

  assign if_valid     = if_valid_r;
  assign id_valid     = id_valid_r;
  assign ex_valid     = ex_valid_r;
  assign mem_valid    = mem_valid_r;
  assign wb_valid     = wb_valid_r;
  assign if_tag       = if_tag_r;
  assign id_tag       = id_tag_r;
  assign ex_tag       = ex_tag_r;
  assign mem_tag      = mem_tag_r;
  assign wb_tag       = wb_tag_r;
  assign retire       = wb_valid_r;
  assign retire_count = retire_count_r;
  assign cycle_count  = cycle_count_r;
  assign done         = done_r;

endmodule
